// File: rtl/md_unit_pkg.sv
// Shared encodings, state constants and default latencies for the md_unit multiply/divide block.
package md_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Operation captured at the start edge; arithmetic only ever sees this copy.
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

endpackage

// File: rtl/md_unit_calc.sv
// md_calc: combinational {HI,LO} result for a latched md request.
// Optional multiply-accumulate (madd/maddu) is enabled by defining MD_MADD_EN.
module md_calc
    import md_unit_pkg::*;
(
    input  md_req_t     req,
`ifdef MD_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] res
);

    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] b_safe;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] dq;
    logic signed [31:0] dr;
    logic        [31:0] uq;
    logic        [31:0] ur;

    // Sign-extended operands give the signed product in the low 64 bits.
    assign prod_s = {{32{req.a[31]}}, req.a} * {{32{req.b[31]}}, req.b};
    assign prod_u = {32'd0, req.a} * {32'd0, req.b};

    // Dividing by 1 on overflow yields exactly quotient 0x80000000, remainder 0.
    assign div_zero = (req.b == 32'd0);
    assign div_ovf  = (req.a == 32'h8000_0000) && (req.b == 32'hFFFF_FFFF);
    assign b_safe   = (div_zero || div_ovf) ? 32'd1 : req.b;

    assign sa = $signed(req.a);
    assign sb = $signed(b_safe);
    assign dq = sa / sb;
    assign dr = sa % sb;
    assign uq = req.a / b_safe;
    assign ur = req.a % b_safe;

    always_comb begin
        res = 64'd0;
        case (req.op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = div_zero ? {req.a, 32'hFFFF_FFFF} : {dr, dq};
            MD_DIVU:  res = div_zero ? {req.a, 32'hFFFF_FFFF} : {ur, uq};
`ifdef MD_MADD_EN
            MD_MADD:  res = acc + prod_s;
            MD_MADDU: res = acc + prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS HI/LO multiply/divide unit with fixed multi-cycle busy latency.
// Define MD_MADD_EN to accept madd/maddu (md_op 4/5); otherwise they are ignored.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    md_req_t          req;
    logic [63:0]      res;
    logic             op_ok;
    logic             is_div;
    logic             go;
    logic             done;

    always_comb begin
        op_ok = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: op_ok = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU:                  op_ok = 1'b1;
`endif
            default:                            op_ok = 1'b0;
        endcase
    end

    assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign go     = start && op_ok && (state == IDLE);
    assign done   = (state == BUSY) && (cnt == CNT_W'(1));

    // Operands are plain data: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (go) begin
            req <= '{op: md_op, a: A, b: B};
        end
    end

    md_calc u_calc (
        .req (req),
`ifdef MD_MADD_EN
        .acc ({hi_q, lo_q}),
`endif
        .res (res)
    );

    // An accepted start takes priority over a same-cycle mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else if (go) begin
            state <= BUSY;
            cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (done) begin
                state        <= IDLE;
                {hi_q, lo_q} <= res;
            end
        end else if (hilo_we) begin
            if (hilo_sel) begin
                hi_q <= wdata;
            end else begin
                lo_q <= wdata;
            end
        end
    end

    assign busy = (state == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
